// File: rtl/instr_mem_ctrl_if.sv
// rtl/instr_mem_ctrl_if.sv - fetch request/response bus for instr_mem_ctrl
// Purpose: carries the valid/ready fetch handshake between a fetch stage
// (master) and instr_mem_ctrl (slave).
// Signals:
//   req_valid, req_pc   master -> slave  fetch request
//   req_ready           slave  -> master request accepted this cycle
//   rsp_valid, rsp_inst slave  -> master registered response
//   rsp_fault           slave  -> master response is for an out-of-range pc
//   rsp_ready           master -> slave  consumer accepts the response
//   parity_err          slave  -> master only with INSTR_MEM_PARITY_EN
interface instr_mem_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int PC_W  = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [PC_W-1:0]  req_pc;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_inst;
  logic             rsp_fault;
`ifdef INSTR_MEM_PARITY_EN
  logic             parity_err;

  modport master (
    output req_valid, req_pc, rsp_ready,
    input  req_ready, rsp_valid, rsp_inst, rsp_fault, parity_err
  );
  modport slave (
    input  req_valid, req_pc, rsp_ready,
    output req_ready, rsp_valid, rsp_inst, rsp_fault, parity_err
  );
`else
  modport master (
    output req_valid, req_pc, rsp_ready,
    input  req_ready, rsp_valid, rsp_inst, rsp_fault
  );
  modport slave (
    input  req_valid, req_pc, rsp_ready,
    output req_ready, rsp_valid, rsp_inst, rsp_fault
  );
`endif
endinterface

// File: rtl/instr_mem_ctrl.sv
// rtl/instr_mem_ctrl.sv - run-time loadable instruction memory with valid/ready fetch port
// Purpose: instruction storage between the fetch stage and the program loader.
// LOAD state accepts writes over the load port; RUN state serves fetches with
// one cycle of registered latency and back-pressure. Out-of-range pcs return
// a fault response instead of aliasing.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   load_start / load_done       pulses to enter LOAD / RUN
//   load_we, load_addr, load_data word write port (LOAD only)
//   bus                          instr_mem_ctrl_if slave (fetch req/rsp)
//   running                      high in RUN state
// Optional macro INSTR_MEM_PARITY_EN: stores an even-parity bit per word and
// reports mismatches on bus.parity_err.
module instr_mem_ctrl #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int PC_W  = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_start,
  input  logic             load_we,
  input  logic [AW-1:0]    load_addr,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_done,
  instr_mem_ctrl_if.slave  bus,
  output logic             running
);

  typedef enum logic {ST_LOAD, ST_RUN} state_t;

`ifdef INSTR_MEM_PARITY_EN
  localparam int MW = WIDTH + 1;
`else
  localparam int MW = WIDTH;
`endif

  // Comparison width wide enough for both the full pc and DEPTH itself.
  localparam int CW = ((PC_W > AW) ? PC_W : AW) + 1;
  localparam logic [CW-1:0] DEPTH_CW = CW'(DEPTH);

  state_t state_q, state_d;

  logic [MW-1:0] mem [DEPTH];
  logic [MW-1:0] wr_word;
  logic [MW-1:0] rd_word;
  logic          load_in_range;
  logic          pc_in_range;
  logic          accept;

  // load_start has priority over load_done in the same cycle.
  always_comb begin
    state_d = state_q;
    if (load_start) begin
      state_d = ST_LOAD;
    end else if (state_q == ST_LOAD && load_done) begin
      state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  assign running = (state_q == ST_RUN);

  assign load_in_range = CW'(load_addr) < DEPTH_CW;
  assign pc_in_range   = CW'(bus.req_pc) < DEPTH_CW;

`ifdef INSTR_MEM_PARITY_EN
  assign wr_word = {^load_data, load_data};
`else
  assign wr_word = load_data;
`endif

  // Storage has no reset so a program survives a controller reset.
  always_ff @(posedge clk) begin
    if (state_q == ST_LOAD && load_we && load_in_range) begin
      mem[load_addr] <= wr_word;
    end
  end

  assign rd_word = mem[bus.req_pc[AW-1:0]];

  assign bus.req_ready = running && (!bus.rsp_valid || bus.rsp_ready);
  assign accept        = bus.req_valid && bus.req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rsp_valid  <= 1'b0;
      bus.rsp_inst   <= '0;
      bus.rsp_fault  <= 1'b0;
`ifdef INSTR_MEM_PARITY_EN
      bus.parity_err <= 1'b0;
`endif
    end else if (load_start) begin
      // Leaving RUN discards whatever response is pending or being accepted.
      bus.rsp_valid <= 1'b0;
    end else if (accept) begin
      bus.rsp_valid <= 1'b1;
      if (pc_in_range) begin
        bus.rsp_inst  <= rd_word[WIDTH-1:0];
        bus.rsp_fault <= 1'b0;
      end else begin
        bus.rsp_inst  <= '0;
        bus.rsp_fault <= 1'b1;
      end
`ifdef INSTR_MEM_PARITY_EN
      // XOR over data plus stored even-parity bit is 1 on mismatch.
      bus.parity_err <= pc_in_range && (^rd_word);
`endif
    end else if (bus.rsp_valid && bus.rsp_ready) begin
      bus.rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// tb/tb_instr_mem_ctrl.sv - self-checking bench for instr_mem_ctrl
module tb_instr_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        load_start;
  logic        load_we;
  logic [3:0]  load_addr;
  logic [31:0] load_data;
  logic        load_done;
  logic        running;

  int checks;
  int failures;

  instr_mem_ctrl_if #(.WIDTH(32), .PC_W(32)) bus ();

  instr_mem_ctrl #(.WIDTH(32), .DEPTH(16), .PC_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .load_we    (load_we),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .load_done  (load_done),
    .bus        (bus),
    .running    (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ls;
    logic        we;
    logic [3:0]  la;
    logic [31:0] ld;
    logic        done;
    logic        rv;
    logic [31:0] pc;
    logic        rr;
    logic        e_rdy;
    logic        e_v;
    logic [31:0] e_inst;
    logic        e_f;
    logic        e_run;
  } vec_t;

  vec_t vecs[27];

  function automatic vec_t mk(logic ls, logic we, logic [3:0] la, logic [31:0] ld,
                              logic done, logic rv, logic [31:0] pc, logic rr,
                              logic e_rdy, logic e_v, logic [31:0] e_inst,
                              logic e_f, logic e_run);
    vec_t v;
    v.ls = ls; v.we = we; v.la = la; v.ld = ld; v.done = done;
    v.rv = rv; v.pc = pc; v.rr = rr;
    v.e_rdy = e_rdy; v.e_v = e_v; v.e_inst = e_inst; v.e_f = e_f; v.e_run = e_run;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    load_start   = v.ls;
    load_we      = v.we;
    load_addr    = v.la;
    load_data    = v.ld;
    load_done    = v.done;
    bus.req_valid = v.rv;
    bus.req_pc    = v.pc;
    bus.rsp_ready = v.rr;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    //               ls we la  ld            dn rv pc            rr  rdy v  inst          f  run
    vecs[0]  = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,        0,  0, 0, 32'h0,         0, 0);
    vecs[1]  = mk(0, 1, 0, 32'h1111_0000, 0, 1, 32'h0,        1,  0, 0, 32'h0,         0, 0);
    vecs[2]  = mk(0, 1, 1, 32'h2222_0001, 0, 0, 32'h0,        1,  0, 0, 32'h0,         0, 0);
    vecs[3]  = mk(0, 1, 2, 32'h3333_0002, 0, 0, 32'h0,        1,  0, 0, 32'h0,         0, 0);
    vecs[4]  = mk(0, 1, 3, 32'h4444_0003, 1, 0, 32'h0,        1,  0, 0, 32'h0,         0, 0);
    vecs[5]  = mk(0, 0, 0, 32'h0,         0, 1, 32'h0,        1,  1, 0, 32'h0,         0, 1);
    vecs[6]  = mk(0, 0, 0, 32'h0,         0, 1, 32'h1,        1,  1, 1, 32'h1111_0000, 0, 1);
    vecs[7]  = mk(0, 0, 0, 32'h0,         0, 1, 32'h3,        1,  1, 1, 32'h2222_0001, 0, 1);
    vecs[8]  = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,        1,  1, 1, 32'h4444_0003, 0, 1);
    vecs[9]  = mk(0, 0, 0, 32'h0,         0, 1, 32'h1,        0,  1, 0, 32'h4444_0003, 0, 1);
    vecs[10] = mk(0, 0, 0, 32'h0,         0, 1, 32'h2,        0,  0, 1, 32'h2222_0001, 0, 1);
    vecs[11] = mk(0, 0, 0, 32'h0,         0, 1, 32'h2,        0,  0, 1, 32'h2222_0001, 0, 1);
    vecs[12] = mk(0, 0, 0, 32'h0,         0, 1, 32'h2,        0,  0, 1, 32'h2222_0001, 0, 1);
    vecs[13] = mk(0, 0, 0, 32'h0,         0, 1, 32'h2,        1,  1, 1, 32'h2222_0001, 0, 1);
    vecs[14] = mk(0, 0, 0, 32'h0,         0, 1, 32'd16,       1,  1, 1, 32'h3333_0002, 0, 1);
    vecs[15] = mk(0, 0, 0, 32'h0,         0, 1, 32'h1000_0003, 1, 1, 1, 32'h0,         1, 1);
    vecs[16] = mk(0, 1, 0, 32'hDEAD_BEEF, 0, 0, 32'h0,        1,  1, 1, 32'h0,         1, 1);
    vecs[17] = mk(0, 0, 0, 32'h0,         0, 1, 32'h0,        1,  1, 0, 32'h0,         1, 1);
    vecs[18] = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,        1,  1, 1, 32'h1111_0000, 0, 1);
    vecs[19] = mk(0, 0, 0, 32'h0,         0, 1, 32'h2,        0,  1, 0, 32'h1111_0000, 0, 1);
    vecs[20] = mk(1, 0, 0, 32'h0,         0, 0, 32'h0,        0,  0, 1, 32'h3333_0002, 0, 1);
    vecs[21] = mk(0, 0, 0, 32'h0,         0, 1, 32'h0,        1,  0, 0, 32'h3333_0002, 0, 0);
    vecs[22] = mk(1, 0, 0, 32'h0,         1, 1, 32'h0,        1,  0, 0, 32'h3333_0002, 0, 0);
    vecs[23] = mk(0, 0, 0, 32'h0,         1, 1, 32'h0,        1,  0, 0, 32'h3333_0002, 0, 0);
    vecs[24] = mk(0, 0, 0, 32'h0,         1, 1, 32'h0,        1,  1, 0, 32'h3333_0002, 0, 1);
    vecs[25] = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,        1,  1, 1, 32'h1111_0000, 0, 1);
    vecs[26] = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,        1,  1, 0, 32'h1111_0000, 0, 1);

    rst = 1'b1;
    drive(vecs[0]);
    #2;
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("reset_rsp_inst", bus.rsp_inst, 32'h0);
    chk("reset_rsp_fault", 32'(bus.rsp_fault), 32'h0);
    chk("reset_running", 32'(running), 32'h0);
    chk("reset_req_ready", 32'(bus.req_ready), 32'h0);
`ifdef INSTR_MEM_PARITY_EN
    chk("reset_parity_err", 32'(bus.parity_err), 32'h0);
`endif
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 27; i++) begin
      drive(vecs[i]);
      @(negedge clk);
      chk($sformatf("v%0d_req_ready", i), 32'(bus.req_ready), 32'(vecs[i].e_rdy));
      chk($sformatf("v%0d_rsp_valid", i), 32'(bus.rsp_valid), 32'(vecs[i].e_v));
      chk($sformatf("v%0d_rsp_inst", i), bus.rsp_inst, vecs[i].e_inst);
      chk($sformatf("v%0d_rsp_fault", i), 32'(bus.rsp_fault), 32'(vecs[i].e_f));
      chk($sformatf("v%0d_running", i), 32'(running), 32'(vecs[i].e_run));
      @(posedge clk);
      #1;
    end

    // Reset asserted between edges while a response is pending.
    drive(mk(0, 0, 0, 32'h0, 0, 1, 32'h0, 0, 0, 0, 32'h0, 0, 0));
    @(posedge clk);
    #1;
    chk("midfetch_pending_valid", 32'(bus.rsp_valid), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("midfetch_rst_valid", 32'(bus.rsp_valid), 32'h0);
    chk("midfetch_rst_running", 32'(running), 32'h0);
    chk("midfetch_rst_req_ready", 32'(bus.req_ready), 32'h0);
    chk("midfetch_rst_inst", bus.rsp_inst, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(mk(0, 0, 0, 32'h0, 1, 0, 32'h0, 1, 0, 0, 32'h0, 0, 0));
    @(posedge clk);
    #1;
    drive(mk(0, 0, 0, 32'h0, 0, 1, 32'h0, 1, 0, 0, 32'h0, 0, 0));
    @(negedge clk);
    chk("retain_req_ready", 32'(bus.req_ready), 32'h1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("retain_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    chk("retain_rsp_inst", bus.rsp_inst, 32'h1111_0000);
    chk("retain_rsp_fault", 32'(bus.rsp_fault), 32'h0);

`ifdef INSTR_MEM_PARITY_EN
    @(posedge clk);
    #1;
    dut.mem[2][0] = ~dut.mem[2][0];
    bus.req_valid = 1'b1;
    bus.req_pc    = 32'h2;
    @(posedge clk);
    #1;
    bus.req_pc = 32'h1;
    @(negedge clk);
    chk("parity_bad_err", 32'(bus.parity_err), 32'h1);
    chk("parity_bad_inst", bus.rsp_inst, 32'h3333_0003);
    @(posedge clk);
    #1;
    bus.req_pc = 32'd16;
    @(negedge clk);
    chk("parity_good_err", 32'(bus.parity_err), 32'h0);
    chk("parity_good_inst", bus.rsp_inst, 32'h2222_0001);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("parity_fault_err", 32'(bus.parity_err), 32'h0);
    chk("parity_fault_flag", 32'(bus.rsp_fault), 32'h1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
